// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA data mover and its config slave.
package dma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } dma_state_e;

  // Register map of the config slave that drives this mover.
  localparam logic [7:0] REG_SR  = 8'h00;
  localparam logic [7:0] REG_CTR = 8'h04;
  localparam logic [7:0] REG_CR  = 8'h08;
  localparam logic [7:0] REG_SRC = 8'h0C;
  localparam logic [7:0] REG_DST = 8'h10;
  localparam logic [7:0] REG_LEN = 8'h14;

  localparam logic [31:0] WORD_BYTES = 32'd4;

  // Status register bit positions built from busy/done/err.
  localparam int SR_BUSY_BIT = 0;
  localparam int SR_DONE_BIT = 1;
  localparam int SR_ERR_BIT  = 2;

endpackage

// File: rtl/dma_buf.sv
// Burst staging buffer: read responses land here, write commands drain it.
module dma_buf
  import dma_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Capture one response word per cycle; contents need no reset since
  // every slot is written before it is read in a burst.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dma_icb_master.sv
// DMA data mover: copies len_words words from src to dst over one ICB
// initiator port, in read-then-write bursts of up to BUF_DEPTH words.
module dma_icb_master
  import dma_pkg::*;
#(
  parameter int BUF_DEPTH = 8,
  parameter int LEN_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len_words,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             dma_icb_cmd_valid,
  input  logic             dma_icb_cmd_ready,
  output logic             dma_icb_cmd_read,
  output logic [31:0]      dma_icb_cmd_addr,
  output logic [31:0]      dma_icb_cmd_wdata,
  output logic [3:0]       dma_icb_cmd_wmask,
  input  logic             dma_icb_rsp_valid,
  output logic             dma_icb_rsp_ready,
  input  logic [31:0]      dma_icb_rsp_rdata,
  input  logic             dma_icb_rsp_err
);

  localparam int AW    = $clog2(BUF_DEPTH);
  localparam int CNT_W = AW + 1;

  dma_state_e       state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] cmd_cnt_q, cmd_cnt_d;
  logic [CNT_W-1:0] rsp_cnt_q, rsp_cnt_d;
  logic             err_q, err_d;

  logic             cmd_valid_q, cmd_valid_d;
  logic             cmd_read_q, cmd_read_d;
  logic [31:0]      cmd_addr_q, cmd_addr_d;
  logic [31:0]      cmd_wdata_q, cmd_wdata_d;
  logic [3:0]       cmd_wmask_q, cmd_wmask_d;

  logic             active;
  logic             cmd_hsk;
  logic             rsp_take;
  logic             err_set;
  logic [CNT_W-1:0] idx_next;
  logic [LEN_W-1:0] rem_after;
  logic [31:0]      addr_base;
  logic [31:0]      buf_rdata;
  logic             issue_ok;

  // Burst size for the next chunk: whatever is left, capped at the buffer depth.
  function automatic logic [CNT_W-1:0] burst_len(input logic [LEN_W-1:0] r);
    if (r >= LEN_W'(BUF_DEPTH)) begin
      return CNT_W'(BUF_DEPTH);
    end
    return r[CNT_W-1:0];
  endfunction

  assign active    = (state_q == RD) || (state_q == WR);
  assign cmd_hsk   = cmd_valid_q & dma_icb_cmd_ready;
  assign rsp_take  = dma_icb_rsp_valid & active;
  assign err_set   = rsp_take & dma_icb_rsp_err;
  assign idx_next  = cmd_cnt_q + CNT_W'(cmd_hsk);
  assign rem_after = rem_q - LEN_W'(n_q);
  assign addr_base = (state_q == RD) ? src_q : dst_q;

  dma_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk   (clk),
    .we    ((state_q == RD) && dma_icb_rsp_valid),
    .waddr (rsp_cnt_q[AW-1:0]),
    .wdata (dma_icb_rsp_rdata),
    .raddr (idx_next[AW-1:0]),
    .rdata (buf_rdata)
  );

  // Next-state, burst bookkeeping and the registered command channel.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    rem_d     = rem_q;
    n_d       = n_q;
    cmd_cnt_d = cmd_cnt_q + CNT_W'(cmd_hsk);
    rsp_cnt_d = rsp_cnt_q + CNT_W'(rsp_take);
    err_d     = err_q | err_set;

    case (state_q)
      IDLE: begin
        if (start) begin
          src_d     = src_addr & 32'hFFFF_FFFC;
          dst_d     = dst_addr & 32'hFFFF_FFFC;
          rem_d     = len_words;
          err_d     = 1'b0;
          cmd_cnt_d = '0;
          rsp_cnt_d = '0;
          if (len_words == '0) begin
            state_d = DONE;
          end else begin
            n_d     = burst_len(len_words);
            state_d = RD;
          end
        end
      end
      RD: begin
        if (err_q) begin
          if (!cmd_valid_q && (cmd_cnt_q == rsp_cnt_q)) begin
            state_d = DONE;
          end
        end else if (rsp_cnt_q == n_q) begin
          state_d   = WR;
          cmd_cnt_d = '0;
          rsp_cnt_d = '0;
        end
      end
      WR: begin
        if (err_q) begin
          if (!cmd_valid_q && (cmd_cnt_q == rsp_cnt_q)) begin
            state_d = DONE;
          end
        end else if (rsp_cnt_q == n_q) begin
          src_d     = src_q + 32'(n_q) * WORD_BYTES;
          dst_d     = dst_q + 32'(n_q) * WORD_BYTES;
          rem_d     = rem_after;
          cmd_cnt_d = '0;
          rsp_cnt_d = '0;
          if (rem_after == '0) begin
            state_d = DONE;
          end else begin
            n_d     = burst_len(rem_after);
            state_d = RD;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    issue_ok = active && !err_q && !err_set && (state_d == state_q) && (idx_next < n_q);

    cmd_valid_d = cmd_valid_q;
    cmd_read_d  = cmd_read_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    cmd_wmask_d = cmd_wmask_q;
    if (!cmd_valid_q || dma_icb_cmd_ready) begin
      cmd_valid_d = 1'b0;
      cmd_read_d  = 1'b0;
      cmd_addr_d  = '0;
      cmd_wdata_d = '0;
      cmd_wmask_d = 4'h0;
      if (issue_ok) begin
        cmd_valid_d = 1'b1;
        cmd_read_d  = (state_q == RD);
        cmd_addr_d  = addr_base + (32'(idx_next) << 2);
        cmd_wdata_d = (state_q == RD) ? 32'h0 : buf_rdata;
        cmd_wmask_d = (state_q == RD) ? 4'h0 : 4'hF;
      end
    end
  end

  // State, counters, addresses and command registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      rem_q       <= '0;
      n_q         <= '0;
      cmd_cnt_q   <= '0;
      rsp_cnt_q   <= '0;
      err_q       <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_read_q  <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_wmask_q <= 4'h0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      rem_q       <= rem_d;
      n_q         <= n_d;
      cmd_cnt_q   <= cmd_cnt_d;
      rsp_cnt_q   <= rsp_cnt_d;
      err_q       <= err_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_read_q  <= cmd_read_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      cmd_wmask_q <= cmd_wmask_d;
    end
  end

  assign busy              = (state_q != IDLE);
  assign done              = (state_q == DONE);
  assign err               = err_q;
  assign dma_icb_cmd_valid = cmd_valid_q;
  assign dma_icb_cmd_read  = cmd_read_q;
  assign dma_icb_cmd_addr  = cmd_addr_q;
  assign dma_icb_cmd_wdata = cmd_wdata_q;
  assign dma_icb_cmd_wmask = cmd_wmask_q;
  assign dma_icb_rsp_ready = 1'b1;

endmodule
